// File: rtl/keypad_scanner.sv
// Purpose : scans a ROWS x COLS key matrix, debounces press and release, reports one event per press.
// Latency : key_valid rises DEBOUNCE-1 edges after the sampling edge that first sees a single closed column.
// Backpr. : event held in a valid/ack register; a press that completes while an event is pending sets overrun.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   reset      asynchronous active-high reset
//   col_in     column sense lines, 1 = key closed on the driven row
//   row_drive  registered one-hot row drive
//   key_valid  key_code holds an unconsumed event
//   key_code   row*COLS + col of the reported key
//   key_ack    consumer accepts the event at this edge (ignored while key_valid = 0)
//   overrun    sticky: a debounced press was dropped because an event was still pending
module keypad_scanner #(
    parameter int ROWS     = 4,
    parameter int COLS     = 3,
    parameter int SETTLE   = 2,
    parameter int DEBOUNCE = 4,
    localparam int CODE_W  = $clog2(ROWS * COLS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [COLS-1:0]   col_in,
    output logic [ROWS-1:0]   row_drive,
    output logic              key_valid,
    output logic [CODE_W-1:0] key_code,
    input  logic              key_ack,
    output logic              overrun
);

    localparam int ROW_W = $clog2(ROWS);
    // A single-cycle settle still needs a one-bit counter to keep the compare well formed.
    localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int DB_W  = $clog2(DEBOUNCE);

    localparam logic [1:0] ST_SCAN    = 2'd0;
    localparam logic [1:0] ST_DEBOUNCE = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    logic [1:0]        state_q,     state_d;
    logic [ROW_W-1:0]  row_idx_q,   row_idx_d;
    logic [ROWS-1:0]   row_drive_q, row_drive_d;
    logic [SET_W-1:0]  settle_q,    settle_d;
    logic [DB_W-1:0]   match_q,     match_d;
    logic [DB_W-1:0]   rel_q,       rel_d;
    logic [COLS-1:0]   col_lat_q,   col_lat_d;
    logic              key_valid_q, key_valid_d;
    logic [CODE_W-1:0] key_code_q,  key_code_d;
    logic              overrun_q,   overrun_d;

    logic              emit;
    logic [ROW_W-1:0]  row_next;
    logic [CODE_W-1:0] emit_code;
    int                col_pos;
    int                code_sum;

    always_comb begin
        state_d     = state_q;
        row_idx_d   = row_idx_q;
        settle_d    = settle_q;
        match_d     = match_q;
        rel_d       = rel_q;
        col_lat_d   = col_lat_q;
        key_valid_d = key_valid_q;
        key_code_d  = key_code_q;
        overrun_d   = overrun_q;
        emit        = 1'b0;

        row_next = (row_idx_q == ROW_W'(ROWS - 1)) ? '0 : row_idx_q + 1'b1;

        // Column index of the latched one-hot pattern.
        col_pos = 0;
        for (int c = 0; c < COLS; c++) begin
            if (col_lat_q[c]) begin
                col_pos = c;
            end
        end
        code_sum  = int'(row_idx_q) * COLS + col_pos;
        emit_code = CODE_W'(code_sum);

        case (state_q)
            ST_SCAN: begin
                if (settle_q == SET_W'(SETTLE - 1)) begin
                    settle_d = '0;
                    // Multi-bit patterns are ghosting or chords: skip the row.
                    if ($onehot(col_in)) begin
                        col_lat_d = col_in;
                        match_d   = DB_W'(1);
                        state_d   = ST_DEBOUNCE;
                    end else begin
                        row_idx_d = row_next;
                    end
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            ST_DEBOUNCE: begin
                if (col_in == col_lat_q) begin
                    if (match_q == DB_W'(DEBOUNCE - 1)) begin
                        emit    = 1'b1;
                        rel_d   = '0;
                        state_d = ST_RELEASE;
                    end else begin
                        match_d = match_q + 1'b1;
                    end
                end else begin
                    state_d   = ST_SCAN;
                    row_idx_d = row_next;
                    settle_d  = '0;
                end
            end
            ST_RELEASE: begin
                if (col_in == '0) begin
                    if (rel_q == DB_W'(DEBOUNCE - 1)) begin
                        state_d   = ST_SCAN;
                        row_idx_d = row_next;
                        settle_d  = '0;
                        rel_d     = '0;
                    end else begin
                        rel_d = rel_q + 1'b1;
                    end
                end else begin
                    rel_d = '0;
                end
            end
            default: begin
                state_d   = ST_SCAN;
                row_idx_d = '0;
                settle_d  = '0;
            end
        endcase

        // Ack frees the register; an emit on the same edge refills it.
        if (key_ack && key_valid_q) begin
            key_valid_d = 1'b0;
        end
        if (emit) begin
            if (!key_valid_q || key_ack) begin
                key_valid_d = 1'b1;
                key_code_d  = emit_code;
            end else begin
                overrun_d = 1'b1;
            end
        end

        row_drive_d = ROWS'(1) << row_idx_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_SCAN;
            row_idx_q   <= '0;
            row_drive_q <= ROWS'(1);
            settle_q    <= '0;
            match_q     <= '0;
            rel_q       <= '0;
            col_lat_q   <= '0;
            key_valid_q <= 1'b0;
            key_code_q  <= '0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_idx_q   <= row_idx_d;
            row_drive_q <= row_drive_d;
            settle_q    <= settle_d;
            match_q     <= match_d;
            rel_q       <= rel_d;
            col_lat_q   <= col_lat_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
            overrun_q   <= overrun_d;
        end
    end

    assign row_drive = row_drive_q;
    assign key_valid = key_valid_q;
    assign key_code  = key_code_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Purpose : self-checking bench for keypad_scanner (vector table, corner sequences, random vs model).
// Latency : outputs sampled on the falling edge after each rising edge.
// Backpr. : key_ack driven from tables, sequences and at random.
module tb_keypad_scanner;

    localparam int ROWS     = 4;
    localparam int COLS     = 3;
    localparam int SETTLE   = 2;
    localparam int DEBOUNCE = 4;
    localparam int CODE_W   = $clog2(ROWS * COLS);
    localparam int OUT_W    = ROWS + 1 + CODE_W + 1;
    localparam int NVEC     = 18;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [COLS-1:0]   col_in = '0;
    logic [ROWS-1:0]   row_drive;
    logic              key_valid;
    logic [CODE_W-1:0] key_code;
    logic              key_ack = 1'b0;
    logic              overrun;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model outputs.
    int m_row;
    bit exp_valid;
    bit exp_ovr;
    int exp_code;

    typedef struct {
        logic [COLS-1:0]   col;
        logic              ack;
        logic [ROWS-1:0]   row;
        logic              vld;
        logic [CODE_W-1:0] code;
        logic              ovr;
    } vec_t;

    vec_t vecs[NVEC];

    keypad_scanner #(
        .ROWS(ROWS), .COLS(COLS), .SETTLE(SETTLE), .DEBOUNCE(DEBOUNCE)
    ) dut (
        .clk(clk),
        .reset(reset),
        .col_in(col_in),
        .row_drive(row_drive),
        .key_valid(key_valid),
        .key_code(key_code),
        .key_ack(key_ack),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic check_out(input string name, input logic [ROWS-1:0] row, input logic vld,
                             input logic [CODE_W-1:0] code, input logic ovr);
        logic [OUT_W-1:0] act;
        logic [OUT_W-1:0] exp;
        act = {row_drive, key_valid, key_code, overrun};
        exp = {row, vld, code, ovr};
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: row/vld/code/ovr got %b/%b/%0d/%b required %b/%b/%0d/%b at t=%0t",
                     name, row_drive, key_valid, key_code, overrun, row, vld, code, ovr, $time);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b required %b at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        col_in  = '0;
        key_ack = 1'b0;
        reset   = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Drive inputs, take one rising edge, return at the following falling edge.
    task automatic step(input logic [COLS-1:0] c, input logic a);
        col_in  = c;
        key_ack = a;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic setv(input int i, input logic [COLS-1:0] c, input logic a, input logic [ROWS-1:0] r,
                        input logic v, input logic [CODE_W-1:0] k, input logic o);
        vecs[i].col  = c;
        vecs[i].ack  = a;
        vecs[i].row  = r;
        vecs[i].vld  = v;
        vecs[i].code = k;
        vecs[i].ovr  = o;
    endtask

    // Output register behaviour at one rising edge.
    task automatic m_edge(input bit emit, input int code);
        if (emit) begin
            if (!exp_valid || key_ack) begin
                exp_valid = 1'b1;
                exp_code  = code;
            end else begin
                exp_ovr = 1'b1;
            end
        end else if (key_ack) begin
            exp_valid = 1'b0;
        end
    endtask

    // Timeline model: walks rows, confirms a single closed column for DEBOUNCE
    // samples, then waits for DEBOUNCE consecutive open samples.
    task automatic model_thread();
        logic [COLS-1:0] pat;
        int k;
        int cidx;
        int zeros;
        bit ok;
        m_row     = 0;
        exp_valid = 1'b0;
        exp_ovr   = 1'b0;
        exp_code  = 0;
        forever begin
            for (int s = 0; s < SETTLE - 1; s++) begin
                @(posedge clk);
                m_edge(1'b0, 0);
            end
            @(posedge clk);
            pat = col_in;
            m_edge(1'b0, 0);
            if ($countones(pat) == 1) begin
                cidx = 0;
                for (int c = 0; c < COLS; c++) if (pat[c]) cidx = c;
                ok = 1'b1;
                k  = 1;
                while (ok && k < DEBOUNCE) begin
                    @(posedge clk);
                    if (col_in != pat) begin
                        ok = 1'b0;
                        m_edge(1'b0, 0);
                    end else begin
                        m_edge(k == DEBOUNCE - 1, m_row * COLS + cidx);
                    end
                    k++;
                end
                if (ok) begin
                    zeros = 0;
                    while (zeros < DEBOUNCE) begin
                        @(posedge clk);
                        m_edge(1'b0, 0);
                        zeros = (col_in == '0) ? zeros + 1 : 0;
                    end
                end
            end
            m_row = (m_row + 1) % ROWS;
        end
    endtask

    initial begin
        logic [ROWS-1:0] er;
        logic [COLS-1:0] cv;
        logic [COLS-1:0] keys [ROWS];
        int cur_key;
        int ghost_key;
        bit saw_valid;

        // Idle scan, clean press of key 7 (row 2, col 1), ack, release.
        setv(0,  3'b000, 0, 4'b0001, 0, 0, 0);
        setv(1,  3'b000, 0, 4'b0010, 0, 0, 0);
        setv(2,  3'b000, 0, 4'b0010, 0, 0, 0);
        setv(3,  3'b000, 0, 4'b0100, 0, 0, 0);
        setv(4,  3'b010, 0, 4'b0100, 0, 0, 0);
        setv(5,  3'b010, 0, 4'b0100, 0, 0, 0);
        setv(6,  3'b010, 0, 4'b0100, 0, 0, 0);
        setv(7,  3'b010, 0, 4'b0100, 0, 0, 0);
        setv(8,  3'b010, 0, 4'b0100, 1, 7, 0);
        setv(9,  3'b010, 0, 4'b0100, 1, 7, 0);
        setv(10, 3'b010, 0, 4'b0100, 1, 7, 0);
        setv(11, 3'b010, 1, 4'b0100, 0, 7, 0);
        setv(12, 3'b000, 0, 4'b0100, 0, 7, 0);
        setv(13, 3'b000, 0, 4'b0100, 0, 7, 0);
        setv(14, 3'b000, 0, 4'b0100, 0, 7, 0);
        setv(15, 3'b000, 0, 4'b1000, 0, 7, 0);
        setv(16, 3'b000, 0, 4'b1000, 0, 7, 0);
        setv(17, 3'b000, 0, 4'b0001, 0, 7, 0);

        do_reset();
        check_out("reset", 4'b0001, 0, 0, 0);
        for (int i = 0; i < NVEC; i++) begin
            step(vecs[i].col, vecs[i].ack);
            check_out($sformatf("vec%0d", i), vecs[i].row, vecs[i].vld, vecs[i].code, vecs[i].ovr);
        end

        // Bounce on row 0 shorter than the debounce window.
        do_reset();
        step(3'b001, 0);
        step(3'b001, 0);
        step(3'b000, 0);
        check_out("bounce_resume", 4'b0010, 0, 0, 0);
        saw_valid = 1'b0;
        repeat (20) begin
            step(3'b000, 0);
            saw_valid = saw_valid | key_valid;
        end
        check_bit("bounce_no_event", saw_valid, 1'b0);

        // Two columns closed on row 1.
        do_reset();
        step(3'b000, 0);
        step(3'b000, 0);
        step(3'b011, 0);
        step(3'b011, 0);
        check_out("multi_skip", 4'b0100, 0, 0, 0);
        step(3'b000, 0);
        step(3'b000, 0);
        check_out("multi_next", 4'b1000, 0, 0, 0);

        // Key 0 left unacknowledged, then key 5 completes: dropped, overrun.
        do_reset();
        repeat (4) step(3'b001, 0);
        check_out("ovr_pre_emit", 4'b0001, 0, 0, 0);
        step(3'b001, 0);
        check_out("ovr_key0", 4'b0001, 1, 0, 0);
        repeat (4) step(3'b000, 0);
        check_out("ovr_release", 4'b0010, 1, 0, 0);
        repeat (5) step(3'b100, 0);
        check_out("ovr_set", 4'b0010, 1, 0, 1);

        // Same, with ack on the emit edge of key 5.
        do_reset();
        check_out("reset_clears_ovr", 4'b0001, 0, 0, 0);
        repeat (5) step(3'b001, 0);
        repeat (4) step(3'b000, 0);
        repeat (4) step(3'b100, 0);
        check_out("ack_pre_emit", 4'b0010, 1, 0, 0);
        step(3'b100, 1);
        check_out("ack_emit", 4'b0010, 1, 5, 0);
        step(3'b100, 0);
        check_out("ack_hold", 4'b0010, 1, 5, 0);

        // Asynchronous reset while debouncing a key on row 3.
        do_reset();
        repeat (6) step(3'b000, 0);
        check_out("rst_mid_row3", 4'b1000, 0, 0, 0);
        repeat (4) step(3'b001, 0);
        check_out("rst_mid_debounce", 4'b1000, 0, 0, 0);
        #2 reset = 1'b1;
        #1 check_out("rst_mid_async", 4'b0001, 0, 0, 0);
        @(negedge clk);
        reset  = 1'b0;
        col_in = '0;
        saw_valid = 1'b0;
        repeat (12) begin
            step(3'b000, 0);
            saw_valid = saw_valid | key_valid;
        end
        check_bit("rst_mid_no_event", saw_valid, 1'b0);

        // Random presses, bounces, glitches and acks against the model.
        do_reset();
        for (int r = 0; r < ROWS; r++) keys[r] = '0;
        cur_key   = -1;
        ghost_key = -1;
        fork
            model_thread();
        join_none
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (cur_key < 0) begin
                if ($urandom_range(19) == 0) cur_key = int'($urandom_range(ROWS * COLS - 1));
            end else if ($urandom_range(24) == 0) begin
                cur_key = -1;
            end
            if (ghost_key < 0) begin
                if ($urandom_range(199) == 0) ghost_key = int'($urandom_range(ROWS * COLS - 1));
            end else if ($urandom_range(9) == 0) begin
                ghost_key = -1;
            end
            for (int r = 0; r < ROWS; r++) keys[r] = '0;
            if (cur_key >= 0) keys[cur_key / COLS][cur_key % COLS] = 1'b1;
            if (ghost_key >= 0) keys[ghost_key / COLS][ghost_key % COLS] = 1'b1;
            cv = keys[m_row];
            if ($urandom_range(19) == 0) cv = cv ^ COLS'($urandom_range((1 << COLS) - 1));
            step(cv, ($urandom_range(2) == 0));
            er = '0;
            er[m_row] = 1'b1;
            check_out("random", er, exp_valid, CODE_W'(exp_code), exp_ovr);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Parametrised, clocked successor to the combinational keypad encoder. Drives keypad rows one at a time and samples the column lines. Each press is debounced on press and on release, and is reported once as a linear key index through a valid/ack output register. It sits between the keypad pins and any consumer that needs one event per key press.

## Interface
- ROWS, 4: number of row lines driven; ROWS >= 2
- COLS, 3: number of column lines sensed; COLS >= 2
- SETTLE, 2: cycles each row is driven before its columns are sampled; SETTLE >= 1
- DEBOUNCE, 4: consecutive stable cycles required for press and for release; DEBOUNCE >= 2
- CODE_W (localparam): $clog2(ROWS*COLS)
- clk  input  1  clock; all state changes on rising edge
- reset  input  1  asynchronous, active-high reset
- col_in  input  COLS  column sense lines, 1 = key closed on the driven row; synchronous to clk
- row_drive  output  ROWS  one-hot row drive, registered
- key_valid  output  1  key_code holds an unconsumed event
- key_code  output  CODE_W  row*COLS + col of the reported key (defaults: 0..11)
- key_ack  input  1  consumer accepts the event at this edge while key_valid = 1
- overrun  output  1  sticky flag: a debounced press was lost because key_valid was still high

## Operation
- Reset values: state SCAN, row index 0, row_drive = 1 (row 0), settle, debounce and release counters 0, key_valid 0, key_code 0, overrun 0.
- Internal registers: row index, latched column one-hot (COLS bits), counters.
- SCAN state:
  - Row index r is driven for SETTLE cycles. The settle counter runs 0..SETTLE-1.
  - col_in is evaluated only on the edge where settle counter = SETTLE-1.
  - Exactly one col_in bit set: latch the column pattern and go to DEBOUNCE with match count 1.
  - Zero bits, or two or more bits set (ghost/multi-key): advance r, wrapping ROWS-1 -> 0, and clear the settle counter.
- DEBOUNCE state:
  - row_drive stays on r.
  - col_in equal to the latched pattern: increment the match count.
  - Any mismatch: return to SCAN with r advanced.
  - Match while count = DEBOUNCE-1: emit the event and go to RELEASE.
- Emit rule:
  - key_valid = 0, or key_ack = 1 this edge: load key_code = r*COLS + c and set key_valid = 1.
  - Otherwise: key_code is unchanged, overrun is set to 1, and the state still goes to RELEASE.
- RELEASE state:
  - row_drive stays on r. Count consecutive cycles with col_in = 0; any nonzero col_in clears the count.
  - When the DEBOUNCE-th consecutive zero is seen: go to SCAN with r advanced and the settle counter at 0.
  - A held key produces no further events.
- Output handshake:
  - key_valid clears on an edge where key_ack = 1, unless an emit occurs at the same edge. If an emit occurs, key_valid stays 1 and key_code takes the new value.
  - key_ack with key_valid = 0 is ignored.
  - key_code is stable while key_valid = 1.
- overrun clears only on reset.

## Timing
- A row is visible on row_drive SETTLE cycles before it is sampled.
- One full scan with no keys pressed takes ROWS*SETTLE cycles.
- Press latency: the detect edge is E0. key_valid is high after edge E0+DEBOUNCE-1, provided col_in stays matching on every edge from E0 to E0+DEBOUNCE-1.
- Release latency: DEBOUNCE edges with col_in = 0; scanning of the next row begins on the following cycle.
- A bounce shorter than DEBOUNCE cycles never produces an event.
- Reset asserted mid-operation: all registers return to reset values immediately (asynchronous), with no pending event or flag retained.

## Test plan
- Reset and idle:
  - Stimulus: pulse reset, hold col_in = 0.
  - Required: row_drive = 0001, key_valid = 0, overrun = 0; row_drive then cycles 0001 -> 0010 -> 0100 -> 1000 -> 0001, each value held 2 cycles.
- Clean press:
  - Stimulus: assert col_in = 010 whenever row_drive = 0100, held for 30 cycles; no key_ack.
  - Required: key_valid rises 3 edges after the detect edge with key_code = 7, exactly one event; then key_ack = 1 for one cycle -> key_valid = 0.
- Bounce:
  - Stimulus: col_in = 001 on row 0 for 2 cycles, then 000.
  - Required: key_valid stays 0, and scanning resumes at row 1.
- Multi-key:
  - Stimulus: col_in = 011 on row 1.
  - Required: no capture, and row_drive advances to 0100.
- Overrun and simultaneous ack:
  - Stimulus: press and release key 0, no ack; press key 5.
  - Required: key_code stays 0 and overrun = 1.
  - Stimulus: repeat with key_ack asserted on the emit edge of key 5.
  - Required: key_valid stays 1 and key_code = 5.
- Reset mid-DEBOUNCE:
  - Stimulus: assert reset 2 cycles after detecting a key on row 3.
  - Required: row_drive = 0001, key_valid = 0, and no event after reset is released.
